fas_frame_serializer: RTL and testbench
=======================================

# fas_frame_serializer

Downstream stage of the frequency-analysis top level. Captures one 16-bin FFT result set on `fft_valid` and the dominant-frequency index on `done`. Serializes both as a framed 32-bit valid/ready word stream toward the host/report interface. Frames arriving while a frame is still in flight are dropped and counted, never merged.

## Interface
Parameters:
- `DONE_TIMEOUT`, default 64: cycles to wait for `done` after bin capture before emitting with the timeout flag; legal range 1..255.

Ports (clock and reset first):
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fft_valid` in 1: one-cycle strobe; `fft_d0`..`fft_d15` are valid this cycle.
- `fft_d0`..`fft_d15` in 32 each: bin k, {real[31:16], imag[15:0]}, passed through unmodified.
- `done` in 1: one-cycle strobe; `freq` is valid this cycle.
- `freq` in 4: dominant bin index.
- `out_ready` in 1: downstream accepts a word this cycle.
- `out_valid` out 1: `out_data` holds a word.
- `out_data` out 32: frame word.
- `out_last` out 1: marks the final word of a frame; qualified by `out_valid`.
- `busy` out 1: high when the state is not IDLE.
- `drop_cnt` out 8: number of frames dropped; saturates at 255.

## Operation
States: IDLE, WAIT_DONE, HDR, BINS, (CHK).
- IDLE + `fft_valid`:
  - Latch all 16 bins into the capture buffer.
  - If `done` is high in the same cycle, latch `freq` and go to HDR.
  - Otherwise clear the timeout counter and go to WAIT_DONE.
- IDLE + `done` alone: ignored.
- WAIT_DONE:
  - On `done`: latch `freq`, set `tflag`=0, go to HDR.
  - Otherwise increment the counter. When it reaches `DONE_TIMEOUT`, set `freq`=4'hF, `tflag`=1, go to HDR.
  - If `done` arrives in the same cycle the counter expires, `done` wins.
- Header word: [31:24]=8'hA5, [23:16]=`frame_id`, [15]=`tflag`, [14:4]=0, [3:0]=freq.
- BINS: emits bins d0..d15 in order. A 4-bit index advances on each accepted word.
- `frame_id`: 8-bit; increments when the last word of a frame is accepted; wraps 255→0.
- `fft_valid` in any state other than IDLE, including the cycle of the last handshake: frame is dropped and `drop_cnt` increments, saturating at 255. The buffer is not disturbed.
- After the last word is accepted, the block returns to IDLE on the next cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `drop_cnt`=0, `frame_id`=0, state IDLE.
- Reset asserted mid-frame abandons the frame. No partial resume; the next frame starts from the header with `frame_id`=0.
- All outputs are registered.
- `fft_valid` and `done` together in cycle 0: header is on `out_data` with `out_valid`=1 in cycle 1.
- `done` arriving N cycles after `fft_valid`: header is valid one cycle after `done`.
- Handshake:
  - A transfer occurs on a cycle where `out_valid` and `out_ready` are both high.
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
- With `out_ready` held high, the frame streams one word per cycle with no bubbles.
- `busy` rises the cycle after capture and falls the cycle after the last transfer.

## Configuration
- `FAS_SER_CHKSUM_EN` defined:
  - After d15, state CHK emits a checksum word: the XOR of the header and all 16 bin words.
  - `out_last` is on the checksum word. Frame length is 18 words.
- Undefined:
  - No CHK state; `out_last` is on the d15 word. Frame length is 17 words.

## Test plan
- Back-to-back: `fft_valid` and `done` together, `freq`=5, bins d_k=32'h0001_0000*k+k, `out_ready`=1.
  - Header 32'hA500_0005 in cycle 1, then 16 bins in order.
  - `out_last` on d15, or on checksum 32'hA500_0005^(XOR of bins) with the macro.
  - `frame_id` is 1 afterwards.
- Delayed done: `done` 10 cycles after `fft_valid` with `freq`=3.
  - Header appears 1 cycle after `done`, value 32'hA5xx_0003.
- Timeout: no `done`, `DONE_TIMEOUT`=64.
  - Header is emitted 65 cycles after capture with bit15=1 and freq field F (32'hA5xx_800F).
- Backpressure: toggle `out_ready` randomly (seeded).
  - `out_data` stays stable while stalled.
  - All 17/18 words are delivered once, in order.
- Drop: second `fft_valid` during BINS, and a third on the last-handshake cycle.
  - `drop_cnt`=2 and the first frame's data is intact.
  - After 300 drops, `drop_cnt`=255.
- Reset mid-BINS: `out_valid`=0 immediately.
  - Next frame's header has `frame_id`=0.

Source files
------------

// File: rtl/fas_frame_serializer.sv
// rtl/fas_frame_serializer.sv - captures 16 FFT bins plus dominant index and streams them as a framed word stream
// Optional checksum word: define FAS_SER_CHKSUM_EN.
module fas_frame_serializer #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  input  logic        done,
  input  logic [3:0]  freq,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DONE,
    ST_HDR,
    ST_BINS,
    ST_CHK
  } state_t;

  // Counter value on which the wait for done gives up (counter starts at 0 on capture).
  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] bin_q [16];
  logic [31:0] bin_d [16];
  logic [31:0] fft_in [16];
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  frame_id_q, frame_id_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
`ifdef FAS_SER_CHKSUM_EN
  logic [31:0] chk_q, chk_d;
`endif

  logic        fire;
  logic        load_hdr;
  logic        hdr_tflag;
  logic [3:0]  hdr_freq;
  logic [31:0] hdr_word;
  logic        frame_end;

  assign fft_in[0]  = fft_d0;
  assign fft_in[1]  = fft_d1;
  assign fft_in[2]  = fft_d2;
  assign fft_in[3]  = fft_d3;
  assign fft_in[4]  = fft_d4;
  assign fft_in[5]  = fft_d5;
  assign fft_in[6]  = fft_d6;
  assign fft_in[7]  = fft_d7;
  assign fft_in[8]  = fft_d8;
  assign fft_in[9]  = fft_d9;
  assign fft_in[10] = fft_d10;
  assign fft_in[11] = fft_d11;
  assign fft_in[12] = fft_d12;
  assign fft_in[13] = fft_d13;
  assign fft_in[14] = fft_d14;
  assign fft_in[15] = fft_d15;

  assign fire = out_valid_q & out_ready;

  // Next-state and registered-output computation for capture, header, bins and checksum.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    idx_d       = idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    frame_id_d  = frame_id_q;
    drop_cnt_d  = drop_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef FAS_SER_CHKSUM_EN
    chk_d       = chk_q;
`endif
    load_hdr    = 1'b0;
    hdr_tflag   = 1'b0;
    hdr_freq    = freq;
    hdr_word    = '0;
    frame_end   = 1'b0;

    // A new frame while one is in flight is discarded; the capture buffer is left alone.
    if (fft_valid && (state_q != ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fft_valid) begin
          bin_d = fft_in;
          if (done) begin
            load_hdr = 1'b1;
          end else begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        // done takes priority over an expiring counter
        if (done) begin
          load_hdr = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          load_hdr  = 1'b1;
          hdr_tflag = 1'b1;
          hdr_freq  = 4'hF;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_HDR: begin
        if (fire) begin
          out_data_d = bin_q[0];
          out_last_d = 1'b0;
          idx_d      = 4'd0;
          state_d    = ST_BINS;
`ifdef FAS_SER_CHKSUM_EN
          chk_d      = chk_q ^ bin_q[0];
`endif
        end
      end
      ST_BINS: begin
        if (fire) begin
          if (idx_q == 4'd15) begin
`ifdef FAS_SER_CHKSUM_EN
            out_data_d = chk_q;
            out_last_d = 1'b1;
            state_d    = ST_CHK;
`else
            frame_end  = 1'b1;
`endif
          end else begin
            out_data_d = bin_q[idx_q + 4'd1];
            idx_d      = idx_q + 4'd1;
`ifdef FAS_SER_CHKSUM_EN
            out_last_d = 1'b0;
            chk_d      = chk_q ^ bin_q[idx_q + 4'd1];
`else
            out_last_d = (idx_q == 4'd14);
`endif
          end
        end
      end
`ifdef FAS_SER_CHKSUM_EN
      ST_CHK: begin
        if (fire) begin
          frame_end = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_hdr) begin
      hdr_word    = {8'hA5, frame_id_q, hdr_tflag, 11'd0, hdr_freq};
      out_valid_d = 1'b1;
      out_data_d  = hdr_word;
      out_last_d  = 1'b0;
      state_d     = ST_HDR;
`ifdef FAS_SER_CHKSUM_EN
      chk_d       = hdr_word;
`endif
    end

    if (frame_end) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      frame_id_d  = frame_id_q + 8'd1;
      state_d     = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      for (int k = 0; k < 16; k++) begin
        bin_q[k] <= '0;
      end
      idx_q       <= '0;
      tmo_cnt_q   <= '0;
      frame_id_q  <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FAS_SER_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      idx_q       <= idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      frame_id_q  <= frame_id_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
`ifdef FAS_SER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fas_frame_serializer.sv
// tb/tb_fas_frame_serializer.sv - self-checking bench for fas_frame_serializer
module tb_fas_frame_serializer;

`ifdef FAS_SER_CHKSUM_EN
  localparam int FRAME_LEN = 18;
`else
  localparam int FRAME_LEN = 17;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] fd [16];
  logic        done;
  logic [3:0]  freq;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] cur_bins [16];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  bit          last_q [$];
  int          stall_viol;
  int          vdrop_viol;
  int          coll_cycles;
  bit          coll_timeout;
  logic [7:0]  m_fid;
  int          m_drop;

  fas_frame_serializer #(.DONE_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done), .freq(freq), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference frame: header, the 16 bins as captured, optional XOR of everything before it.
  task automatic build_expected(input bit tflag, input logic [3:0] f);
    logic [31:0] x;
    exp_q.delete();
    x = {8'hA5, m_fid, tflag, 11'd0, f};
    exp_q.push_back(x);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(cur_bins[k]);
      x = x ^ cur_bins[k];
    end
`ifdef FAS_SER_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic rand_bins();
    for (int k = 0; k < 16; k++) cur_bins[k] = $urandom;
  endtask

  // Called at a negedge; presents a one-cycle capture strobe, returns at the next negedge.
  task automatic start_frame(input bit with_done, input logic [3:0] f);
    for (int k = 0; k < 16; k++) fd[k] = cur_bins[k];
    fft_valid = 1'b1;
    done = with_done;
    freq = f;
    @(negedge clk);
    fft_valid = 1'b0;
    done = 1'b0;
  endtask

  // Receives one frame, recording words, last flags and handshake-rule violations.
  task automatic collect_frame(input bit rand_ready, input int budget);
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    bit          fin;
    got_q.delete();
    last_q.delete();
    stall_viol = 0;
    vdrop_viol = 0;
    coll_cycles = 0;
    coll_timeout = 0;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 1'b0;
    fin = 0;
    while (!fin && !coll_timeout) begin
      if (coll_cycles >= budget) begin
        coll_timeout = 1;
      end else begin
        if (prev_stall) begin
          if (!out_valid) vdrop_viol++;
          else if (out_data !== prev_data || out_last !== prev_last) stall_viol++;
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          last_q.push_back(out_last);
          if (out_last) fin = 1;
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        coll_cycles++;
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
  endtask

  function automatic int count_last();
    int n = 0;
    foreach (last_q[i]) if (last_q[i]) n++;
    return n;
  endfunction

  function automatic bit final_last();
    return (last_q.size() > 0) ? last_q[last_q.size() - 1] : 1'b0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    rst = 1'b1;
    @(negedge clk);
    m_fid = 8'd0;
    m_drop = 0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) cur_bins[k] = 32'h0001_0000 * k + k;
    build_expected(1'b0, 4'd5);
    out_ready = 1'b1;
    start_frame(1'b1, 4'd5);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA500_0005) begin n_fail++; $display("FAIL b2b_header_cycle1: got v=%b d=%h expected v=1 d=a5000005", out_valid, out_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_rise: got %b expected 1", busy); end
    collect_frame(1'b0, 40);
    n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL b2b_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (coll_cycles !== FRAME_LEN) begin n_fail++; $display("FAIL b2b_no_bubbles: got %0d cycles expected %0d", coll_cycles, FRAME_LEN); end
    n_checks++; if (count_last() !== 1 || final_last() !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got count=%0d final=%b expected count=1 final=1", count_last(), final_last()); end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b v=%b expected 0 0", busy, out_valid); end
    m_fid = m_fid + 8'd1;
  endtask

  task automatic test_delayed_done();
    bit early;
    rand_bins();
    build_expected(1'b0, 4'd3);
    early = 0;
    start_frame(1'b0, 4'd0);
    for (int c = 1; c < 10; c++) begin
      if (out_valid) early = 1;
      @(negedge clk);
    end
    if (out_valid) early = 1;
    done = 1'b1;
    freq = 4'd3;
    @(negedge clk);
    done = 1'b0;
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL delayed_early_valid: got %b expected 0", early); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL delayed_header: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_q[0]); end
    n_checks++; if (out_data[31:24] !== 8'hA5 || out_data[15:0] !== 16'h0003) begin n_fail++; $display("FAIL delayed_header_fields: got %h expected a5xx0003", out_data); end
    collect_frame(1'b0, 40);
    n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL delayed_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL delayed_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    m_fid = m_fid + 8'd1;
  endtask

  task automatic test_timeout();
    int k;
    rand_bins();
    build_expected(1'b1, 4'hF);
    start_frame(1'b0, 4'd7);
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k !== 65) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 65", k); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL timeout_header: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_q[0]); end
    collect_frame(1'b1, 200);
    n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL timeout_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    m_fid = m_fid + 8'd1;
  endtask

  task automatic test_backpressure();
    logic [3:0] f;
    for (int r = 0; r < 3; r++) begin
      rand_bins();
      f = 4'($urandom_range(0, 14));
      build_expected(1'b0, f);
      start_frame(1'b1, f);
      collect_frame(1'b1, 400);
      n_checks++; if (coll_timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", coll_timeout); end
      n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol); end
      n_checks++; if (vdrop_viol !== 0) begin n_fail++; $display("FAIL bp_valid_drop: got %0d violations expected 0", vdrop_viol); end
      n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL bp_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
      for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (count_last() !== 1 || final_last() !== 1'b1) begin n_fail++; $display("FAIL bp_last: got count=%0d final=%b expected count=1 final=1", count_last(), final_last()); end
      m_fid = m_fid + 8'd1;
    end
  endtask

  task automatic test_drop();
    bit dropped_mid, fin;
    int cyc;
    logic [3:0] f;
    rand_bins();
    f = 4'($urandom_range(0, 15));
    build_expected(1'b0, f);
    out_ready = 1'b1;
    start_frame(1'b1, f);
    got_q.delete();
    last_q.delete();
    dropped_mid = 0;
    fin = 0;
    cyc = 0;
    while (!fin && cyc < 60) begin
      fft_valid = 1'b0;
      if (out_valid) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (out_valid && out_last) begin
        fin = 1;
        for (int k = 0; k < 16; k++) fd[k] = ~cur_bins[k];
        fft_valid = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else if (!dropped_mid && got_q.size() == 4) begin
        dropped_mid = 1;
        for (int k = 0; k < 16; k++) fd[k] = $urandom;
        fft_valid = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
      @(negedge clk);
      cyc++;
    end
    fft_valid = 1'b0;
    n_checks++; if (drop_cnt !== 8'(m_drop) || m_drop != 2) begin n_fail++; $display("FAIL drop_count: got %0d expected 2", drop_cnt); end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_restart: got busy=%b v=%b expected 0 0", busy, out_valid); end
    n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL drop_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    m_fid = m_fid + 8'd1;
  endtask

  task automatic test_drop_saturate();
    logic [3:0] f;
    rand_bins();
    f = 4'($urandom_range(0, 15));
    build_expected(1'b0, f);
    out_ready = 1'b0;
    start_frame(1'b1, f);
    for (int k = 0; k < 16; k++) fd[k] = $urandom;
    fft_valid = 1'b1;
    repeat (300) @(negedge clk);
    fft_valid = 1'b0;
    m_drop = (m_drop + 300 > 255) ? 255 : m_drop + 300;
    n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL drop_saturate: got %0d expected %0d", drop_cnt, m_drop); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL drop_hold_header: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_q[0]); end
    collect_frame(1'b1, 400);
    n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL sat_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    m_fid = m_fid + 8'd1;
  endtask

  task automatic test_reset_mid_bins();
    logic [3:0] f;
    rand_bins();
    out_ready = 1'b1;
    start_frame(1'b1, 4'd9);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_state: got busy=%b drop=%0d expected 0 0", busy, drop_cnt); end
    @(negedge clk);
    rst = 1'b1;
    m_fid = 8'd0;
    m_drop = 0;
    @(negedge clk);
    rand_bins();
    f = 4'($urandom_range(0, 15));
    build_expected(1'b0, f);
    start_frame(1'b1, f);
    n_checks++; if (out_data[23:16] !== 8'h00) begin n_fail++; $display("FAIL rstmid_frame_id: got %h expected 00", out_data[23:16]); end
    collect_frame(1'b1, 400);
    n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL rstmid_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    m_fid = m_fid + 8'd1;
  endtask

  task automatic test_random_frames();
    int d;
    logic [3:0] f;
    for (int r = 0; r < 5; r++) begin
      rand_bins();
      f = 4'($urandom_range(0, 15));
      d = $urandom_range(0, 6);
      build_expected(1'b0, f);
      if (d == 0) begin
        start_frame(1'b1, f);
      end else begin
        start_frame(1'b0, 4'd0);
        repeat (d - 1) @(negedge clk);
        done = 1'b1;
        freq = f;
        @(negedge clk);
        done = 1'b0;
      end
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_header: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, exp_q[0]); end
      collect_frame(1'b1, 400);
      n_checks++; if (got_q.size() !== FRAME_LEN) begin n_fail++; $display("FAIL rnd_len: got %0d expected %0d", got_q.size(), FRAME_LEN); end
      for (int i = 0; i < FRAME_LEN && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (stall_viol !== 0 || vdrop_viol !== 0) begin n_fail++; $display("FAIL rnd_handshake: got stall=%0d vdrop=%0d expected 0 0", stall_viol, vdrop_viol); end
      m_fid = m_fid + 8'd1;
    end
  endtask

  initial begin
    void'($urandom(32'd20240611));
    rst = 1'b0;
    fft_valid = 1'b0;
    done = 1'b0;
    freq = 4'd0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) fd[k] = '0;
    m_fid = 8'd0;
    m_drop = 0;
    test_reset();
    test_back_to_back();
    test_delayed_done();
    test_timeout();
    test_backpressure();
    test_drop();
    test_drop_saturate();
    test_reset_mid_bins();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
